// File: rtl/arm_imm_pkg.sv
// Shared types and helpers for the rotated-immediate encoder.
// The FSM enum gains SEARCH_INV only when IMM_ENCODER_INV_EN is defined.
package arm_imm_pkg;

  localparam int unsigned IMM8_W = 8;
  localparam int unsigned ROT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SEARCH     = 2'd1,
    S_FINISH     = 2'd2
`ifdef IMM_ENCODER_INV_EN
    , S_SEARCH_INV = 2'd3
`endif
  } enc_state_e;

  // Upper half of the doubled word shifted left is the 32-bit rotate-left.
  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] sh);
    logic [63:0] d;
    d = {x, x} << sh;
    return d[63:32];
  endfunction

endpackage

// File: rtl/imm_rotl.sv
// 32-bit rotate-left by an even amount (2 * half_amt).
module imm_rotl #(
  parameter int unsigned ROT_W = 4
) (
  input  logic [31:0]      data,
  input  logic [ROT_W-1:0] half_amt,
  output logic [31:0]      result
);
  import arm_imm_pkg::*;

  assign result = rotl(data, 5'({half_amt, 1'b0}));

endmodule

// File: rtl/imm_encoder.sv
// Sequential search for an 8-bit immediate + even rotate that reproduces a 32-bit value.
// Optional IMM_ENCODER_INV_EN adds a second search on ~value (MVN substitution).
module imm_encoder #(
  parameter int unsigned ROT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      value,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [7:0]       imm8,
  output logic [ROT_W-1:0] rot,
  output logic [11:0]      shift_operand,
  output logic             inv
);
  import arm_imm_pkg::*;

  enc_state_e       state, state_nx;
  logic [ROT_W-1:0] cnt;
  logic [31:0]      captured, operand, cand;
  logic             hit, last;

`ifdef IMM_ENCODER_INV_EN
  assign operand = (state == S_SEARCH_INV) ? ~captured : captured;
`else
  assign operand = captured;
  assign inv     = 1'b0;
`endif

  imm_rotl #(.ROT_W(ROT_W)) u_rotl (
    .data     (operand),
    .half_amt (cnt),
    .result   (cand)
  );

  assign hit           = (cand[31:IMM8_W] == '0);
  assign last          = (cnt == '1);
  assign shift_operand = 12'({rot, imm8});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = S_SEARCH;
      S_SEARCH: begin
        busy = 1'b1;
        if (hit) state_nx = S_FINISH;
        else if (last) begin
`ifdef IMM_ENCODER_INV_EN
          state_nx = S_SEARCH_INV;
`else
          state_nx = S_FINISH;
`endif
        end
      end
`ifdef IMM_ENCODER_INV_EN
      S_SEARCH_INV: begin
        busy = 1'b1;
        if (hit || last) state_nx = S_FINISH;
      end
`endif
      S_FINISH: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      captured <= '0;
      valid    <= 1'b0;
      imm8     <= '0;
      rot      <= '0;
`ifdef IMM_ENCODER_INV_EN
      inv      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt      <= '0;
          captured <= value;
        end
        S_SEARCH: begin
          if (hit) begin
            imm8  <= cand[7:0];
            rot   <= cnt;
            valid <= 1'b1;
`ifdef IMM_ENCODER_INV_EN
            inv   <= 1'b0;
`endif
          end else if (last) begin
`ifdef IMM_ENCODER_INV_EN
            cnt   <= '0;
`else
            valid <= 1'b0;
            imm8  <= '0;
            rot   <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef IMM_ENCODER_INV_EN
        S_SEARCH_INV: begin
          if (hit) begin
            imm8  <= cand[7:0];
            rot   <= cnt;
            valid <= 1'b1;
            inv   <= 1'b1;
          end else if (last) begin
            valid <= 1'b0;
            imm8  <= '0;
            rot   <= '0;
            inv   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder; latency L means done is first seen
// after edge T+L-1, where T is the edge that samples start.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  logic        busy, done, valid, inv;
  logic [7:0]  imm8;
  logic [3:0]  rot;
  logic [11:0] shift_operand;

  int checks = 0;
  int passed = 0;

  imm_encoder #(.ROT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .value         (value),
    .busy          (busy),
    .done          (done),
    .valid         (valid),
    .imm8          (imm8),
    .rot           (rot),
    .shift_operand (shift_operand),
    .inv           (inv)
  );

  always #5 clk = ~clk;

  task automatic do_encode(input logic [31:0] v, output int lat);
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({busy, done, valid, inv, imm8, rot, shift_operand} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b inv=%b imm8=%h rot=%h so=%h, want all zero",
               busy, done, valid, inv, imm8, rot, shift_operand);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_encode();
    logic [31:0] vals [9];
    logic        e_valid [9];
    logic [7:0]  e_imm [9];
    logic [3:0]  e_rot [9];
    logic        e_inv [9];
    int          e_lat [9];
    int          lat;
    vals = '{32'h000000FF, 32'h00000000, 32'hFF000000, 32'hF000000F, 32'h00000104,
             32'h3FC00000, 32'h00000400, 32'h00000101, 32'hFFFFFF00};
    e_valid = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    e_imm   = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h41, 8'hFF, 8'h01, 8'h00, 8'h00};
    e_rot   = '{4'd0, 4'd0, 4'd4, 4'd2, 4'd15, 4'd5, 4'd11, 4'd0, 4'd0};
    e_inv   = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    e_lat   = '{2, 2, 6, 4, 17, 7, 13, 17, 17};
`ifdef IMM_ENCODER_INV_EN
    e_lat[7]   = 33;
    e_valid[8] = 1'b1;
    e_imm[8]   = 8'hFF;
    e_inv[8]   = 1'b1;
    e_lat[8]   = 18;
`endif
    for (int i = 0; i < 9; i++) begin
      do_encode(vals[i], lat);
      checks++;
      if (lat !== e_lat[i])
        $display("FAIL latency[%h]: got %0d want %0d (0 = timeout)", vals[i], lat, e_lat[i]);
      else passed++;
      checks++;
      if (valid !== e_valid[i]) $display("FAIL valid[%h]: got %b want %b", vals[i], valid, e_valid[i]);
      else passed++;
      checks++;
      if (imm8 !== e_imm[i]) $display("FAIL imm8[%h]: got %h want %h", vals[i], imm8, e_imm[i]);
      else passed++;
      checks++;
      if (rot !== e_rot[i]) $display("FAIL rot[%h]: got %0d want %0d", vals[i], rot, e_rot[i]);
      else passed++;
      checks++;
      if (shift_operand !== {e_rot[i], e_imm[i]})
        $display("FAIL shift_operand[%h]: got %h want %h", vals[i], shift_operand, {e_rot[i], e_imm[i]});
      else passed++;
      checks++;
      if (inv !== e_inv[i]) $display("FAIL inv[%h]: got %b want %b", vals[i], inv, e_inv[i]);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if ({done, busy} !== 2'b00 || imm8 !== e_imm[i])
        $display("FAIL after_done[%h]: got done=%b busy=%b imm8=%h want done=0 busy=0 imm8=%h",
                 vals[i], done, busy, imm8, e_imm[i]);
      else passed++;
    end
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    @(negedge clk);
    value = 32'h00000104;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy);
    else passed++;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    value = 32'h000000FF;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 7; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n + 1;
        break;
      end
    end
    checks++;
    if (lat !== 17 || imm8 !== 8'h41 || rot !== 4'd15 || valid !== 1'b1)
      $display("FAIL ignore_start: got lat=%0d imm8=%h rot=%0d valid=%b want lat=17 imm8=41 rot=15 valid=1",
               lat, imm8, rot, valid);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit saw_done = 0;
    int lat;
    @(negedge clk);
    value = 32'h00000104;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, valid, inv, imm8, rot, shift_operand} !== '0)
      $display("FAIL reset_mid_outputs: got busy=%b done=%b valid=%b inv=%b imm8=%h rot=%h so=%h, want all zero",
               busy, done, valid, inv, imm8, rot, shift_operand);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1;
    end
    checks++;
    if (saw_done !== 1'b0) $display("FAIL reset_mid_no_done: got activity=%b want 0", saw_done);
    else passed++;
    do_encode(32'h000000FF, lat);
    checks++;
    if (lat !== 2 || imm8 !== 8'hFF || rot !== 4'd0 || valid !== 1'b1)
      $display("FAIL restart_after_reset: got lat=%0d imm8=%h rot=%0d valid=%b want lat=2 imm8=ff rot=0 valid=1",
               lat, imm8, rot, valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_encode();
    test_ignore_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter ROT_W, default 4: rotate-field width; the search covers 2**ROT_W rotate positions.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port value  input  32  constant to encode; captured on the accepted start.
REQ-006 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-008 SHALL have port valid  output  1  1 = encodable; meaningful while done is high, held afterward.
REQ-009 SHALL have port imm8  output  8  encoded byte.
REQ-010 SHALL have port rot  output  ROT_W  encoded rotate field.
REQ-011 SHALL have port shift_operand  output  12  {rot, imm8}, the data-processing immediate field.
REQ-012 SHALL have port inv  output  1  1 = encoding is of ~value (MVN substitution); tied 0 when the feature is absent.

Function
REQ-013 Encoding rule: value == ROR(zero-extended imm8, 2*rot) in 32 bits; this is the inverse of the team's Val_2 immediate path.
REQ-014 FSM states: IDLE, SEARCH, (SEARCH_INV under the macro), FINISH.
REQ-015 IDLE -> SEARCH when start=1; the cycle counter is cleared to 0 and value is captured into an internal register.
REQ-016 Each SEARCH cycle tests a single k = counter: cand = ROL(captured, 2*k); hit iff cand[31:8]==0.
REQ-017 On hit: imm8=cand[7:0], rot=k, valid=1, -> FINISH; the smallest k wins.
REQ-018 No hit at k=2**ROT_W-1: valid=0, imm8=0, rot=0, -> FINISH (or -> SEARCH_INV under the macro).
REQ-019 FINISH: done=1 for exactly one cycle, -> IDLE; outputs hold until the next accepted start.
REQ-020 Latency: done is high in cycle T+k+2 for a hit at k (T = start sample edge); a miss gives T+2**ROT_W+1.
REQ-021 start while busy or in FINISH SHALL be ignored, and value changes after capture SHALL have no effect.
REQ-022 value=0 SHALL hit at k=0: imm8=0, rot=0.

Reset
REQ-023 rst=1 SHALL force IDLE at once, clear the counter and captured value, and zero busy, done, valid, imm8, rot, shift_operand and inv, including mid-search; no done pulse follows.
REQ-024 The first start after rst is released SHALL behave as from power-up.

Configuration
REQ-025 Macro IMM_ENCODER_INV_EN: when defined, a positive-search miss SHALL enter SEARCH_INV, which repeats REQ-016/017 on ~captured with the counter restarted at 0 and sets inv=1 on a hit; done is high at T+2**ROT_W+k+2, or at T+2*2**ROT_W+1 on a total miss with valid=0, inv=0.
REQ-026 When IMM_ENCODER_INV_EN is undefined, SEARCH_INV SHALL not exist and inv SHALL be constant 0.

Structure
REQ-027 Shared package arm_imm_pkg SHALL hold the FSM state enum, the IMM8_W=8 and ROT_W=4 constants, and the rotate-left function.
REQ-028 A single sub-module imm_rotl (32-bit rotate-left by an even amount) SHALL be instantiated once and used by both search states.

Verification
REQ-029 value=0x000000FF -> imm8=0xFF, rot=0, valid=1, inv=0, shift_operand=0x0FF, done at T+2.
REQ-030 value=0xFF000000 -> imm8=0xFF, rot=4, done at T+6; value=0xF000000F -> imm8=0xFF, rot=2, done at T+4.
REQ-031 value=0x00000104 -> imm8=0x41, rot=15, done at T+17; value=0x00000101 -> valid=0, done at T+17 (T+33 with the macro).
REQ-032 value=0xFFFFFF00 -> with macro: imm8=0xFF, rot=0, inv=1, done at T+18; without macro: valid=0, done at T+17.
REQ-033 start at k=5 of an active search is ignored; rst at k=5 clears all outputs with no done; a new start afterward completes normally.
